// File: rtl/tic_pkg.sv
// ---------------------------------------------------------------------------
// tic_pkg
// Shared constants and types for the TiCSAT operand feeder.
//   TIC_W     : width of one packed operand word (four int8 lanes)
//   TIC_COLS  : columns per group; words are issued in groups of this size
//   CMD_*     : array command encodings (2'b11 is never driven)
//   state_t   : feeder sequencing state
// ---------------------------------------------------------------------------
package tic_pkg;

    localparam int TIC_W    = 32;
    localparam int TIC_COLS = 4;

    localparam logic [1:0] CMD_STREAM     = 2'b00;
    localparam logic [1:0] CMD_DRAIN      = 2'b01;
    localparam logic [1:0] CMD_DRAIN_LAST = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

endpackage

// File: rtl/tic_feeder_fifo.sv
// ---------------------------------------------------------------------------
// tic_feeder_fifo
// Synchronous operand FIFO with an occupancy count.
//   clk, resetn : clock, asynchronous active-low reset (clears contents)
//   push, wdata : write one word; caller guarantees not full
//   pop, rdata  : rdata is the head word (show-ahead); pop advances it,
//                 caller guarantees not empty
//   count       : number of stored words, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module tic_feeder_fifo
    import tic_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    push,
    input  logic [TIC_W-1:0]        wdata,
    input  logic                    pop,
    output logic [TIC_W-1:0]        rdata,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][TIC_W-1:0] mem;
    logic [AW-1:0]               wptr;
    logic [AW-1:0]               rptr;

    assign rdata = mem[rptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tic_feeder.sv
// ---------------------------------------------------------------------------
// tic_feeder
// Upstream sequencer for the TiCSAT systolic array. Buffers operand words
// from a valid/ready source and drives tic_in/command/col in 4-cycle groups
// aligned to the free-running col counter. A job is a compute phase (groups
// of FIFO words, zero-padded while starved) followed by a drain phase.
//
// Ports
//   clk, resetn           : clock, asynchronous active-low reset
//   s_data/s_valid/s_ready: operand word source (push in any state)
//   start                 : begin a job (sampled in IDLE only)
//   compute_groups        : number of 4-word compute groups (with start)
//   drain_groups          : number of 4-cycle drain groups (with start)
//   busy, done            : job in progress / one-cycle end-of-job pulse
//   tic_in, command, col  : registered array inputs
//   stall_groups          : idle groups inserted during compute
//                           (only when TIC_FEEDER_STATS_EN is defined)
//
// Optional feature macro: TIC_FEEDER_STATS_EN
// ---------------------------------------------------------------------------
module tic_feeder
    import tic_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [TIC_W-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             start,
    input  logic [LEN_W-1:0] compute_groups,
    input  logic [LEN_W-1:0] drain_groups,
    output logic             busy,
    output logic             done,
    output logic [TIC_W-1:0] tic_in,
    output logic [1:0]       command,
    output logic [1:0]       col
`ifdef TIC_FEEDER_STATS_EN
    ,
    output logic [LEN_W-1:0] stall_groups
`endif
);

    localparam int            CW    = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] GROUP = CW'(TIC_COLS);

    state_t           state, state_n;
    logic [LEN_W-1:0] comp_rem, comp_rem_n;
    logic [LEN_W-1:0] drain_lat, drain_lat_n;
    logic [LEN_W-1:0] drain_rem, drain_rem_n;
    logic             issuing, issuing_n;
    logic             busy_n, done_n;
    logic [TIC_W-1:0] tic_n;
    logic [1:0]       cmd_n, col_n;

    logic [CW-1:0]    fifo_count;
    logic [TIC_W-1:0] fifo_rdata;
    logic             push, pop, boundary, launch;

    // Ready comes from the registered count, so a pop while full does not
    // open the port until the following cycle.
    assign s_ready  = (fifo_count < FULL);
    assign push     = s_valid && s_ready;
    assign boundary = (col == 2'd3);

    // A group is only launched with all four words already buffered, since
    // the array cannot be stalled mid-group.
    assign launch = (state == ST_COMPUTE) && boundary &&
                    (comp_rem != '0) && (fifo_count >= GROUP);

    // Word 0 is popped on the boundary edge so it lands on tic_in at col 0;
    // words 1..3 follow on the col 0..2 edges.
    assign pop = launch || (issuing && !boundary);

    tic_feeder_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .wdata  (s_data),
        .pop    (pop),
        .rdata  (fifo_rdata),
        .count  (fifo_count)
    );

    always_comb begin
        state_n     = state;
        comp_rem_n  = comp_rem;
        drain_lat_n = drain_lat;
        drain_rem_n = drain_rem;
        issuing_n   = issuing;
        busy_n      = busy;
        done_n      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    comp_rem_n  = compute_groups;
                    drain_lat_n = drain_groups;
                    busy_n      = 1'b1;
                    state_n     = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if (issuing && col == 2'd2) begin
                    issuing_n = 1'b0;
                end
                if (boundary) begin
                    if (comp_rem == '0) begin
                        if (drain_lat == '0) begin
                            state_n = ST_IDLE;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end else begin
                            state_n     = ST_DRAIN;
                            // counts drain groups still to start after this one
                            drain_rem_n = drain_lat - LEN_W'(1);
                        end
                    end else if (launch) begin
                        issuing_n  = 1'b1;
                        comp_rem_n = comp_rem - LEN_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (boundary) begin
                    if (drain_rem == '0) begin
                        state_n = ST_IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        drain_rem_n = drain_rem - LEN_W'(1);
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end
        endcase

        // Array-facing outputs are computed for the next cycle's col.
        col_n = col + 2'd1;
        tic_n = pop ? fifo_rdata : '0;
        if (state_n == ST_DRAIN) begin
            cmd_n = (col_n == 2'd3) ? CMD_DRAIN_LAST : CMD_DRAIN;
        end else begin
            cmd_n = CMD_STREAM;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            comp_rem  <= '0;
            drain_lat <= '0;
            drain_rem <= '0;
            issuing   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tic_in    <= '0;
            command   <= CMD_STREAM;
            col       <= 2'd0;
        end else begin
            state     <= state_n;
            comp_rem  <= comp_rem_n;
            drain_lat <= drain_lat_n;
            drain_rem <= drain_rem_n;
            issuing   <= issuing_n;
            busy      <= busy_n;
            done      <= done_n;
            tic_in    <= tic_n;
            command   <= cmd_n;
            col       <= col_n;
        end
    end

`ifdef TIC_FEEDER_STATS_EN
    // A compute boundary with groups left but fewer than four words buffered
    // inserts one zero group.
    logic stall;
    assign stall = (state == ST_COMPUTE) && boundary &&
                   (comp_rem != '0) && (fifo_count < GROUP);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_groups <= '0;
        end else if (state == ST_IDLE && start) begin
            stall_groups <= '0;
        end else if (stall && stall_groups != '1) begin
            stall_groups <= stall_groups + LEN_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_tic_feeder.sv
`timescale 1ns/1ps
module tb_tic_feeder;

    localparam int DEPTH = 8;
    localparam int LEN_W = 16;

    logic             clk    = 1'b0;
    logic             resetn = 1'b0;
    logic [31:0]      s_data = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic             start  = 1'b0;
    logic [LEN_W-1:0] compute_groups = '0;
    logic [LEN_W-1:0] drain_groups   = '0;
    logic             busy, done;
    logic [31:0]      tic_in;
    logic [1:0]       command, col;
`ifdef TIC_FEEDER_STATS_EN
    logic [LEN_W-1:0] stall_groups;
`endif

    tic_feeder #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .start          (start),
        .compute_groups (compute_groups),
        .drain_groups   (drain_groups),
        .busy           (busy),
        .done           (done),
        .tic_in         (tic_in),
        .command        (command),
        .col            (col)
`ifdef TIC_FEEDER_STATS_EN
        ,
        .stall_groups   (stall_groups)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Group contents are planned as a queue of future output cycles; FIFO
    // words are bound to a planned slot when that slot is emitted.
    typedef struct {
        logic [31:0] tic;
        logic [1:0]  cmd;
        bit          take;
    } ent_t;
    typedef enum int {M_IDLE, M_COMP, M_DRAIN} mph_t;

    ent_t        plan[$];
    logic [31:0] q[$];
    mph_t        ph = M_IDLE;
    int          m_col = 0;
    int          comp_left = 0;
    int          dl = 0;
    int          m_stall = 0;
    logic [31:0] m_tic = '0;
    logic [1:0]  m_cmd = '0;
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            plan.delete();
            q.delete();
            ph = M_IDLE;
            m_col = 0; comp_left = 0; dl = 0; m_stall = 0;
            m_tic = '0; m_cmd = '0; m_busy = 1'b0; m_done = 1'b0;
        end else begin
            bit   do_push;
            bit   fin;
            ent_t e;
            do_push = s_valid && (q.size() < DEPTH);
            fin = 1'b0;
            if (ph == M_IDLE && start) begin
                comp_left = int'(compute_groups);
                dl        = int'(drain_groups);
                m_stall   = 0;
                ph        = M_COMP;
                m_busy    = 1'b1;
            end else if (m_col == 3 && ph == M_COMP) begin
                if (comp_left == 0) begin
                    if (dl == 0) fin = 1'b1;
                    else begin
                        ph = M_DRAIN;
                        for (int g = 0; g < dl; g++)
                            for (int c = 0; c < 4; c++) begin
                                e.tic = '0; e.take = 1'b0;
                                e.cmd = (c == 3) ? 2'b10 : 2'b01;
                                plan.push_back(e);
                            end
                    end
                end else if (q.size() >= 4) begin
                    for (int c = 0; c < 4; c++) begin
                        e.tic = '0; e.cmd = 2'b00; e.take = 1'b1;
                        plan.push_back(e);
                    end
                    comp_left--;
                end else begin
                    for (int c = 0; c < 4; c++) begin
                        e.tic = '0; e.cmd = 2'b00; e.take = 1'b0;
                        plan.push_back(e);
                    end
                    if (m_stall < 65535) m_stall++;
                end
            end else if (m_col == 3 && ph == M_DRAIN && plan.size() == 0) begin
                fin = 1'b1;
            end
            if (fin) begin
                ph = M_IDLE;
                m_busy = 1'b0;
            end
            m_done = fin;
            if (plan.size() > 0) begin
                e = plan.pop_front();
                if (e.take) e.tic = q.pop_front();
                m_tic = e.tic;
                m_cmd = e.cmd;
            end else begin
                m_tic = '0;
                m_cmd = 2'b00;
            end
            if (do_push) q.push_back(s_data);
            m_col = (m_col + 1) % 4;
        end
    end

    // ---------------- per-cycle compare + literal logs ----------------
    logic [31:0] wlog[$];
    logic [1:0]  clog[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        check("col",     32'(col),     32'(m_col));
        check("tic_in",  tic_in,       m_tic);
        check("command", 32'(command), 32'(m_cmd));
        check("busy",    32'(busy),    32'(m_busy));
        check("done",    32'(done),    32'(m_done));
        check("s_ready", 32'(s_ready), 32'(q.size() < DEPTH));
`ifdef TIC_FEEDER_STATS_EN
        check("stall_groups", 32'(stall_groups), 32'(m_stall));
`endif
        if (resetn) begin
            if (tic_in != '0)     wlog.push_back(tic_in);
            if (command != 2'b00) clog.push_back(command);
            if (done)             done_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        wlog.delete();
        clog.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start(input int cg, input int dg);
        compute_groups = LEN_W'(cg);
        drain_groups   = LEN_W'(dg);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int i;
        i = 0;
        while (done_cnt == 0 && i < limit) begin
            tick();
            i++;
        end
        total++;
        if (done_cnt == 0) begin
            bad++;
            $display("FAIL %s: done_cnt=0 want >=1 within %0d cycles", name, limit);
        end
    endtask

    task automatic check_cmds(input string name, input logic [1:0] exp[$]);
        check({name, "_ncmd"}, 32'(clog.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < clog.size(); i++)
            check({name, "_cmd"}, 32'(clog[i]), 32'(exp[i]));
    endtask

    task automatic check_words(input string name, input logic [31:0] exp[$]);
        check({name, "_nword"}, 32'(wlog.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < wlog.size(); i++)
            check({name, "_word"}, wlog[i], exp[i]);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [1:0]  ec[$];
        logic [31:0] ew[$];
        logic [1:0]  c0;

        resetn = 1'b0;
        tick(3);
        resetn = 1'b1;

        // idle after reset
        tick(5);
        c0 = col;
        tick();
        check("col_step", 32'(col - c0), 32'd1);
        check("idle_busy",  32'(busy),    32'd0);
        check("idle_ready", 32'(s_ready), 32'd1);
        check("idle_tic",   tic_in,       32'd0);

        // one full group then one drain group
        s_valid = 1'b1; s_data = 32'h11011202;
        tick(4);
        s_valid = 1'b0;
        clear_logs();
        pulse_start(1, 1);
        check("t2_busy_rise", 32'(busy), 32'd1);
        wait_done("t2_done", 60);
        tick(3);
        ew = '{32'h11011202, 32'h11011202, 32'h11011202, 32'h11011202};
        check_words("t2", ew);
        ec = '{2'b01, 2'b01, 2'b01, 2'b10};
        check_cmds("t2", ec);
        check("t2_done_cnt", 32'(done_cnt), 32'd1);
        check("t2_busy_fall", 32'(busy), 32'd0);

        // starved compute: two words, then two more later
        s_valid = 1'b1; s_data = 32'hA1A1_0001; tick();
        s_data = 32'hA1A1_0002; tick();
        s_valid = 1'b0;
        clear_logs();
        pulse_start(1, 0);
        tick(14);
        check("t3_still_busy", 32'(busy), 32'd1);
        check("t3_no_words", 32'(wlog.size()), 32'd0);
        s_valid = 1'b1; s_data = 32'hA1A1_0003; tick();
        s_data = 32'hA1A1_0004; tick();
        s_valid = 1'b0;
        wait_done("t3_done", 40);
        tick(2);
        ew = '{32'hA1A1_0001, 32'hA1A1_0002, 32'hA1A1_0003, 32'hA1A1_0004};
        check_words("t3", ew);
        check("t3_ncmd", 32'(clog.size()), 32'd0);
        check("t3_done_cnt", 32'(done_cnt), 32'd1);

        // fill to DEPTH, then keep pushing through pop cycles
        for (int i = 0; i < DEPTH + 3; i++) begin
            s_valid = 1'b1; s_data = 32'h4000_0000 + 32'(i);
            tick();
        end
        check("t4_full_ready", 32'(s_ready), 32'd0);
        clear_logs();
        pulse_start(2, 0);
        for (int i = 0; i < 60 && done_cnt == 0; i++) begin
            s_data = s_data + 32'd1;
            tick();
        end
        s_valid = 1'b0;
        check("t4_done_cnt", 32'(done_cnt), 32'd1);
        tick(2);
        ew.delete();
        for (int i = 0; i < DEPTH; i++) ew.push_back(32'h4000_0000 + 32'(i));
        check_words("t4", ew);

        // drain only
        clear_logs();
        pulse_start(0, 2);
        wait_done("t5_done", 40);
        tick(2);
        ec = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};
        check_cmds("t5", ec);
        check("t5_nword", 32'(wlog.size()), 32'd0);

        // reset mid-compute
        pulse_start(3, 1);
        tick(7);
        resetn = 1'b0;
        #1;
        check("t6_rst_busy",  32'(busy),    32'd0);
        check("t6_rst_done",  32'(done),    32'd0);
        check("t6_rst_tic",   tic_in,       32'd0);
        check("t6_rst_cmd",   32'(command), 32'd0);
        check("t6_rst_col",   32'(col),     32'd0);
        check("t6_rst_ready", 32'(s_ready), 32'd1);
        tick(2);
        resetn = 1'b1;
        clear_logs();
        pulse_start(1, 0);
        tick(12);
        check("t6_empty_busy", 32'(busy), 32'd1);
        check("t6_empty_nword", 32'(wlog.size()), 32'd0);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = 32'hC0DE_0000 + 32'(i);
            tick();
        end
        s_valid = 1'b0;
        wait_done("t6_done", 40);

        // randomized traffic, including start while busy
        for (int i = 0; i < 1500; i++) begin
            s_valid        = ($urandom_range(0, 2) != 0);
            s_data         = $urandom;
            start          = ($urandom_range(0, 15) == 0);
            compute_groups = LEN_W'($urandom_range(0, 3));
            drain_groups   = LEN_W'($urandom_range(0, 2));
            tick();
        end
        start = 1'b0;
        s_valid = 1'b0;
        tick(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
